// File: rtl/traffic_lamp_driver.sv
// Lamp and pedestrian-countdown driver for one traffic path.
// Samples the traffic FSM's car/walk codes, drives the physical lamps two
// clocks later, runs a BCD walk countdown with 7-segment encoding, and latches
// a flashing-red fail-safe after a run of illegal codes.
module traffic_lamp_driver #(
  parameter int unsigned WALK_SEC   = 20,
  parameter int unsigned FAULT_FILT = 3,
  parameter int unsigned BLINK_DIV  = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       sec_tick,
  input  logic [3:0] car_traffic,
  input  logic [1:0] walk_traffic,
  output logic       car_red,
  output logic       car_yellow,
  output logic       car_left,
  output logic       car_green,
  output logic       walk_red,
  output logic       walk_green,
  output logic       cd_valid,
  output logic [3:0] cd_tens,
  output logic [3:0] cd_ones,
  output logic [6:0] seg_tens,
  output logic [6:0] seg_ones,
  output logic       fault
);

  localparam int unsigned CAR_W   = 4;
  localparam int unsigned WALK_W  = 2;
  localparam int unsigned FCNT_W  = 4;
  localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [CAR_W-1:0]  CAR_RED_CODE  = 4'b1000;
  localparam logic [WALK_W-1:0] WALK_RED_CODE = 2'b10;
  localparam logic [WALK_W-1:0] WALK_BAD_CODE = 2'b11;
  localparam logic [FCNT_W-1:0] FCNT_MAX      = '1;
  localparam logic [BLINK_W-1:0] BLINK_LAST   = BLINK_W'(BLINK_DIV - 1);
  localparam logic [3:0]        LOAD_TENS     = 4'((WALK_SEC / 10) % 10);
  localparam logic [3:0]        LOAD_ONES     = 4'(WALK_SEC % 10);
  localparam logic [6:0]        SEG_BLANK     = 7'h7F;

  // Stage-1 sample registers
  logic [CAR_W-1:0]   car_q;
  logic [WALK_W-1:0]  walk_q;
  logic [WALK_W-1:0]  walk_prev;

  // Fault filter and blink state
  logic [FCNT_W-1:0]  flt_cnt;
  logic [FCNT_W-1:0]  flt_cnt_nxt;
  logic               fault_nxt;
  logic               car_onehot;
  logic               sample_legal;
  logic [BLINK_W-1:0] blink_cnt;
  logic [BLINK_W-1:0] blink_cnt_nxt;
  logic               blink_ph;
  logic               blink_ph_nxt;

  // Stage-2 next values
  logic       car_red_nxt;
  logic       car_yellow_nxt;
  logic       car_left_nxt;
  logic       car_green_nxt;
  logic       walk_red_nxt;
  logic       walk_green_nxt;
  logic       cd_valid_nxt;
  logic [3:0] cd_tens_nxt;
  logic [3:0] cd_ones_nxt;
  logic       load_evt;

  // BCD digit to active-low {g..a} segments; non-BCD values blank
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Legality of the stage-1 sample and the saturating illegal-run counter
  always_comb begin
    car_onehot   = (car_q != '0) && ((car_q & (car_q - CAR_W'(1))) == '0);
    sample_legal = car_onehot && (walk_q != WALK_BAD_CODE);
    flt_cnt_nxt  = flt_cnt;
    if (sample_legal) begin
      flt_cnt_nxt = '0;
    end else if (flt_cnt != FCNT_MAX) begin
      flt_cnt_nxt = flt_cnt + FCNT_W'(1);
    end
    fault_nxt = fault | (32'(flt_cnt_nxt) >= FAULT_FILT);
  end

  // Blink phase divider, running only while the fault is latched
  always_comb begin
    blink_cnt_nxt = '0;
    blink_ph_nxt  = 1'b0;
    if (fault) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt_nxt = '0;
        blink_ph_nxt  = ~blink_ph;
      end else begin
        blink_cnt_nxt = blink_cnt + BLINK_W'(1);
        blink_ph_nxt  = blink_ph;
      end
    end
  end

  // Lamp decode: follow the sampled codes, or flash red in fault mode
  always_comb begin
    car_red_nxt    = car_q[3];
    car_yellow_nxt = car_q[2];
    car_left_nxt   = car_q[1];
    car_green_nxt  = car_q[0];
    walk_red_nxt   = walk_q[1];
    walk_green_nxt = walk_q[0];
    if (fault) begin
      car_red_nxt    = blink_ph;
      car_yellow_nxt = 1'b0;
      car_left_nxt   = 1'b0;
      car_green_nxt  = 1'b0;
      walk_red_nxt   = 1'b0;
      walk_green_nxt = 1'b0;
    end
  end

  // Countdown: clear on walk red or fault, load on leaving red, else BCD tick down
  always_comb begin
    cd_valid_nxt = cd_valid;
    cd_tens_nxt  = cd_tens;
    cd_ones_nxt  = cd_ones;
    load_evt     = (walk_prev == WALK_RED_CODE) && (walk_q != WALK_RED_CODE);
    if (fault || (walk_q == WALK_RED_CODE)) begin
      cd_valid_nxt = 1'b0;
      cd_tens_nxt  = '0;
      cd_ones_nxt  = '0;
    end else if (load_evt) begin
      cd_valid_nxt = 1'b1;
      cd_tens_nxt  = LOAD_TENS;
      cd_ones_nxt  = LOAD_ONES;
    end else if (sec_tick && cd_valid) begin
      if (cd_ones != 4'd0) begin
        cd_ones_nxt = cd_ones - 4'd1;
      end else if (cd_tens != 4'd0) begin
        cd_tens_nxt = cd_tens - 4'd1;
        cd_ones_nxt = 4'd9;
      end
    end
  end

  // Segment outputs; tens digit suppressed when zero
  always_comb begin
    seg_tens = SEG_BLANK;
    seg_ones = SEG_BLANK;
    if (cd_valid) begin
      seg_ones = seg7(cd_ones);
      if (cd_tens != 4'd0) begin
        seg_tens = seg7(cd_tens);
      end
    end
  end

  // Sample, filter, blink, lamp and countdown registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      car_q      <= CAR_RED_CODE;
      walk_q     <= WALK_RED_CODE;
      walk_prev  <= WALK_RED_CODE;
      flt_cnt    <= '0;
      fault      <= 1'b0;
      blink_cnt  <= '0;
      blink_ph   <= 1'b0;
      car_red    <= 1'b0;
      car_yellow <= 1'b0;
      car_left   <= 1'b0;
      car_green  <= 1'b0;
      walk_red   <= 1'b0;
      walk_green <= 1'b0;
      cd_valid   <= 1'b0;
      cd_tens    <= '0;
      cd_ones    <= '0;
    end else begin
      car_q      <= car_traffic;
      walk_q     <= walk_traffic;
      walk_prev  <= walk_q;
      flt_cnt    <= flt_cnt_nxt;
      fault      <= fault_nxt;
      blink_cnt  <= blink_cnt_nxt;
      blink_ph   <= blink_ph_nxt;
      car_red    <= car_red_nxt;
      car_yellow <= car_yellow_nxt;
      car_left   <= car_left_nxt;
      car_green  <= car_green_nxt;
      walk_red   <= walk_red_nxt;
      walk_green <= walk_green_nxt;
      cd_valid   <= cd_valid_nxt;
      cd_tens    <= cd_tens_nxt;
      cd_ones    <= cd_ones_nxt;
    end
  end

endmodule
